// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int STATE_W = 2;

  localparam logic [DATA_W-1:0] NOP_INST     = 32'h0000_0013;
  localparam logic [DATA_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [DATA_W-1:0] PC_STEP      = 32'd4;
  localparam logic [DATA_W-1:0] ALIGN_MASK   = {{(DATA_W-2){1'b1}}, 2'b00};

  typedef enum logic [STATE_W-1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, one-entry skid buffer,
// redirect/flush handling and the IF_ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imemReqValid,
  output logic [DATA_W-1:0] imemReqAddr,
  input  logic              imemReqReady,
  input  logic              imemRspValid,
  input  logic [DATA_W-1:0] imemRspData,
  input  logic              stall,
  input  logic              redirectValid,
  input  logic [DATA_W-1:0] redirectPC,
  output logic [DATA_W-1:0] ifidInst,
  output logic [DATA_W-1:0] ifidPC,
  output logic              ifidValid
);

  fetch_state_e      state_q, state_d;
  logic              req_valid_q;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] req_pc_q;
  logic [DATA_W-1:0] hold_inst_q;
  logic [DATA_W-1:0] if_inst_q, if_pc_q;
  logic              if_valid_q;

  logic              handshake;
  logic              rsp_in_wait;
  logic              deliver;
  logic [DATA_W-1:0] deliver_inst;

  assign handshake    = (state_q == ST_REQ) && req_valid_q && imemReqReady;
  assign rsp_in_wait  = (state_q == ST_WAIT) && imemRspValid;
  assign deliver      = !redirectValid && !stall && (rsp_in_wait || (state_q == ST_HOLD));
  assign deliver_inst = (state_q == ST_HOLD) ? hold_inst_q : imemRspData;

  assign pc_d = redirectValid ? align_word(redirectPC) :
                handshake     ? pc_q + PC_STEP        : pc_q;

  // NOTE: every path starts from a default assignment so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:  if (handshake) state_d = redirectValid ? ST_DROP : ST_WAIT;
      // A response landing in the redirect cycle retires the outstanding
      // request, so there is nothing left to drop.
      ST_WAIT: begin
        if (imemRspValid)       state_d = (stall && !redirectValid) ? ST_HOLD : ST_REQ;
        else if (redirectValid) state_d = ST_DROP;
      end
      ST_HOLD: if (redirectValid || !stall) state_d = ST_REQ;
      ST_DROP: if (imemRspValid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      req_valid_q <= 1'b0;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == ST_REQ);
      pc_q        <= pc_d;
      if (handshake) req_pc_q <= pc_q;

      if (redirectValid) begin
        if_valid_q <= 1'b0;
        if_inst_q  <= NOP_INST;
      end else if (deliver) begin
        if_valid_q <= 1'b1;
        if_inst_q  <= deliver_inst;
        if_pc_q    <= req_pc_q;
      end else if (!stall) begin
        if_valid_q <= 1'b0;
        if_inst_q  <= NOP_INST;
      end
    end
  end

  // NOTE: the skid buffer is pure datapath qualified by state, so it carries
  // no reset and stays out of the reset tree.
  always_ff @(posedge clk) begin
    if (rsp_in_wait && stall && !redirectValid) hold_inst_q <= imemRspData;
  end

  assign imemReqValid = req_valid_q;
  assign imemReqAddr  = pc_q;
  assign ifidInst     = if_inst_q;
  assign ifidPC       = if_pc_q;
  assign ifidValid    = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic [31:0] ifidInst;
  logic [31:0] ifidPC;
  logic        ifidValid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRspValid  (imemRspValid),
    .imemRspData   (imemRspData),
    .stall         (stall),
    .redirectValid (redirectValid),
    .redirectPC    (redirectPC),
    .ifidInst      (ifidInst),
    .ifidPC        (ifidPC),
    .ifidValid     (ifidValid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: a fetch is either outstanding, buffered, or neither.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_pending;
  bit          m_doomed;
  logic [31:0] m_pend_pc;
  slot_t       m_buf[$];
  bit          m_if_valid;
  logic [31:0] m_if_inst;
  logic [31:0] m_if_pc;

  // Memory environment
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          mem_delay_cfg;
  bit          use_forced;
  logic [31:0] forced_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_req_valid();
    return m_started && !m_pending && (m_buf.size() == 0);
  endfunction

  task automatic model_reset();
    m_started  = 1'b0;
    m_pc       = 32'h0;
    m_pending  = 1'b0;
    m_doomed   = 1'b0;
    m_pend_pc  = 32'h0;
    m_buf.delete();
    m_if_valid = 1'b0;
    m_if_inst  = NOP;
    m_if_pc    = 32'h0;
  endtask

  task automatic model_step();
    bit    hs;
    bit    have;
    slot_t s;
    hs   = exp_req_valid() && imemReqReady;
    have = 1'b0;
    if (redirectValid) begin
      m_pc = redirectPC & 32'hFFFF_FFFC;
      m_buf.delete();
      m_if_valid = 1'b0;
      m_if_inst  = NOP;
      if (hs) begin
        m_pending = 1'b1;
        m_doomed  = 1'b1;
      end else if (m_pending) begin
        if (imemRspValid) m_pending = 1'b0;
        else              m_doomed  = 1'b1;
      end
    end else begin
      if (hs) begin
        m_pending = 1'b1;
        m_doomed  = 1'b0;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else if (m_pending && imemRspValid) begin
        m_pending = 1'b0;
        if (!m_doomed) begin
          s.inst = imemRspData;
          s.pc   = m_pend_pc;
          if (stall) m_buf.push_back(s);
          else       have = 1'b1;
        end
      end else if (m_buf.size() > 0 && !stall) begin
        s    = m_buf.pop_front();
        have = 1'b1;
      end
      if (have) begin
        m_if_valid = 1'b1;
        m_if_inst  = s.inst;
        m_if_pc    = s.pc;
      end else if (!stall) begin
        m_if_valid = 1'b0;
        m_if_inst  = NOP;
      end
    end
    m_started = 1'b1;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("cyc_req_valid", imemReqValid, exp_req_valid());
      if (exp_req_valid()) check("cyc_req_addr", imemReqAddr, m_pc);
      check_bit("cyc_ifid_valid", ifidValid, m_if_valid);
      check("cyc_ifid_inst", ifidInst, m_if_inst);
      if (m_if_valid) check("cyc_ifid_pc", ifidPC, m_if_pc);
    end
  end

  // One clock: model and memory advance on the edge, next inputs driven #1 later.
  task automatic tick(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit vld;
    @(negedge clk);
    vld = imemReqValid;
    @(posedge clk);
    if (rst_n) model_step();
    if (imemRspValid) mem_busy = 1'b0;
    if (vld && imemReqReady && rst_n) begin
      mem_busy = 1'b1;
      mem_cnt  = (mem_delay_cfg != 0) ? mem_delay_cfg : int'($urandom_range(1, 3));
      mem_data = use_forced ? forced_data : $urandom;
    end
    #1;
    stall         = st;
    redirectValid = rd;
    redirectPC    = rpc;
    imemReqReady  = rdy;
    imemRspValid  = mem_busy && (mem_cnt == 1);
    imemRspData   = imemRspValid ? mem_data : 32'hDEAD_BEEF;
    if (mem_busy && mem_cnt > 1) mem_cnt--;
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    stall         = 1'b0;
    redirectValid = 1'b0;
    redirectPC    = 32'h0;
    imemReqReady  = 1'b0;
    imemRspValid  = 1'b0;
    imemRspData   = 32'h0;
    mem_busy      = 1'b0;
    model_reset();
    #1;
    check_bit({tag, "_req_valid"}, imemReqValid, 1'b0);
    check_bit({tag, "_ifid_valid"}, ifidValid, 1'b0);
    check({tag, "_ifid_inst"}, ifidInst, NOP);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirectValid = 1'b0; redirectPC = 32'h0;
    imemReqReady = 1'b0; imemRspValid = 1'b0; imemRspData = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0; mem_data = 32'h0;
    mem_delay_cfg = 1; use_forced = 1'b1; forced_data = 32'h0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release and first fetch with a zero-wait memory
    forced_data = 32'h00A00093;
    check_bit("rel_req_low", imemReqValid, 1'b0);
    tick(0, 0, 32'h0, 1);
    check_bit("first_req_valid", imemReqValid, 1'b1);
    check("first_req_addr", imemReqAddr, 32'h0);
    tick(0, 0, 32'h0, 1);
    forced_data = 32'h00208133;
    tick(1, 0, 32'h0, 1);
    check("t1_inst", ifidInst, 32'h00A00093);
    check("t1_pc", ifidPC, 32'h0);
    check_bit("t1_valid", ifidValid, 1'b1);
    check("t1_next_addr", imemReqAddr, 32'h4);

    // Three stall cycles while the next response arrives
    tick(1, 0, 32'h0, 1);
    check("st_hold_inst_a", ifidInst, 32'h00A00093);
    check_bit("st_noreq_a", imemReqValid, 1'b0);
    tick(1, 0, 32'h0, 0);
    check("st_hold_inst_b", ifidInst, 32'h00A00093);
    check_bit("st_noreq_b", imemReqValid, 1'b0);
    tick(0, 0, 32'h0, 0);
    check("st_hold_pc_c", ifidPC, 32'h0);
    check_bit("st_noreq_c", imemReqValid, 1'b0);
    tick(0, 0, 32'h0, 1);
    check("st_rel_inst", ifidInst, 32'h00208133);
    check("st_rel_pc", ifidPC, 32'h4);
    check_bit("st_rel_valid", ifidValid, 1'b1);

    // Redirect while the request is in flight
    mem_delay_cfg = 2;
    tick(0, 1, 32'h0000_0103, 1);
    check_bit("st_no_dup", ifidValid, 1'b0);
    tick(0, 0, 32'h0, 0);
    check_bit("rw_flush_valid", ifidValid, 1'b0);
    check("rw_flush_inst", ifidInst, NOP);
    check_bit("rw_noreq", imemReqValid, 1'b0);
    tick(0, 0, 32'h0, 1);
    check_bit("rw_req_valid", imemReqValid, 1'b1);
    check("rw_req_addr", imemReqAddr, 32'h0000_0100);
    check_bit("rw_dropped", ifidValid, 1'b0);

    // Redirect while holding a buffered instruction under stall
    mem_delay_cfg = 1;
    forced_data = 32'h00100113;
    tick(0, 0, 32'h0, 1);
    forced_data = 32'h00300193;
    tick(1, 0, 32'h0, 1);
    check("rh_pre_pc", ifidPC, 32'h0000_0100);
    tick(1, 0, 32'h0, 0);
    tick(1, 1, 32'h0000_0200, 0);
    check_bit("rh_hold_valid", ifidValid, 1'b1);
    check_bit("rh_hold_noreq", imemReqValid, 1'b0);
    forced_data = 32'h00400213;
    tick(1, 0, 32'h0, 1);
    check_bit("rh_flush_valid", ifidValid, 1'b0);
    check("rh_flush_inst", ifidInst, NOP);
    check("rh_target_addr", imemReqAddr, 32'h0000_0200);
    tick(0, 0, 32'h0, 0);
    check_bit("rh_discarded", ifidValid, 1'b0);
    tick(0, 1, 32'hFFFF_FFFF, 0);
    check("rh_new_inst", ifidInst, 32'h00400213);
    check("rh_new_pc", ifidPC, 32'h0000_0200);

    // PC wrap at the top of the address space
    tick(0, 0, 32'h0, 1);
    check("wr_addr_top", imemReqAddr, 32'hFFFF_FFFC);
    tick(0, 0, 32'h0, 0);
    tick(1, 0, 32'h0, 1);
    check("wr_pc_top", ifidPC, 32'hFFFF_FFFC);
    check("wr_next_addr", imemReqAddr, 32'h0);

    // Asynchronous reset while waiting on a response
    tick(1, 0, 32'h0, 0);
    check_bit("ar_pre_valid", ifidValid, 1'b1);
    do_reset("ar");
    imemRspValid = 1'b1;
    imemRspData  = 32'hBAD0_0BAD;
    tick(0, 0, 32'h0, 1);
    check_bit("ar_req_valid", imemReqValid, 1'b1);
    check("ar_req_addr", imemReqAddr, 32'h0);
    check_bit("ar_late_ignored", ifidValid, 1'b0);

    // Randomized traffic
    use_forced    = 1'b0;
    mem_delay_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 7);
      if (i == 1500) begin
        @(negedge clk);
        do_reset("rr");
      end
    end

    tick(0, 0, 32'h0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
